// File: rtl/sseg_pkg.sv
// Shared constants, slot-state type and pattern slicing helper for the
// seven-segment scan controller.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int         NDIG      = 4;
  localparam int         SEG_W     = 7;
  localparam int         LOAD_W    = NDIG * SEG_W;

  typedef enum logic {
    BLANK,
    DRIVE
  } slot_state_t;

  // Pull the 7-bit pattern for digit idx out of a packed load word.
  function automatic logic [SEG_W-1:0] digit_slice(input logic [LOAD_W-1:0] data,
                                                   input int idx);
    return data[idx*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Pattern-set load port: valid/ready handshake carrying four packed digits.
interface sseg_scan_ctrl_if;
  import sseg_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [LOAD_W-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/slot_timer.sv
// Per-digit slot prescaler: counts system clocks 0..TICK_DIV-1 and flags the
// last cycle of each slot.
module slot_timer #(
  parameter int TICK_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [$clog2(TICK_DIV)-1:0] cnt,
  output logic                        slot_end
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  assign slot_end = (cnt == LAST);

  // Free-running slot counter that wraps to zero on the last slot cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode scan controller: double-buffered pattern load,
// per-slot dead time, per-digit enable and registered anode/segment drive.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  sseg_scan_ctrl_if.slave  load,
  input  logic [NDIG-1:0]  dig_en,
  output logic [3:0]       an,
  output logic [6:0]       sseg,
  output logic             frame_start
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]    cnt;
  logic             slot_end;
  logic [1:0]       dig;
  logic [NDIG-1:0]  en_q;
  logic             pending;
  logic [SEG_W-1:0] active [NDIG];
  logic [SEG_W-1:0] shadow [NDIG];
  slot_state_t      slot_state;
  logic             frame_wrap;

  slot_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  assign slot_state     = (int'(cnt) < BLANK_CYC) ? BLANK : DRIVE;
  assign frame_wrap     = slot_end && (dig == 2'(NDIG - 1));
  assign load.load_ready = ~pending;

  // Digit index and enable latch both advance only at slot boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig  <= '0;
      en_q <= '1;
    end else if (slot_end) begin
      dig  <= dig + 2'd1;
      en_q <= dig_en;
    end
  end

  // Double buffer: fill the shadow while empty, promote it at a frame wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        active[i] <= SEG_BLANK;
        shadow[i] <= SEG_BLANK;
      end
    end else if (pending) begin
      if (frame_wrap) begin
        for (int i = 0; i < NDIG; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end
    end else if (load.load_valid) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= digit_slice(load.load_data, i);
      end
      pending <= 1'b1;
    end
  end

  // Registered display drive and frame marker, one cycle behind the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an          <= AN_OFF;
      sseg        <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (slot_state == BLANK || !en_q[dig]) begin
        an   <= AN_OFF;
        sseg <= SEG_BLANK;
      end else begin
        an   <= ~(4'b0001 << dig);
        sseg <= active[dig];
      end
    end
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Scan controller for the board's 4-digit common-anode seven-segment display. It takes four pre-decoded 7-bit segment patterns through a valid/ready load port, double-buffers them, and time-multiplexes them onto `an`/`sseg` at a parameterised per-digit slot rate. Each slot starts with an anti-ghosting dead time, and each digit can be individually enabled. It replaces the clock-divider-plus-mux pair: it runs on the system clock with an internal prescaler, so no derived clock is used.

## Interface
- `TICK_DIV`, default 100000: system-clock cycles per digit slot. Legal range is ≥ 2. The default gives 1 kHz per digit at 100 MHz.
- `BLANK_CYC`, default 1000: dead-time cycles at the start of each slot. Legal range is 0 ≤ `BLANK_CYC` < `TICK_DIV`.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  new pattern set offered.
- `load_ready`  out  1  controller can accept a pattern set.
- `load_data`  in  28  patterns: digit0 in [6:0], digit1 in [13:7], digit2 in [20:14], digit3 in [27:21]. Active-low segments, passed through unmodified.
- `dig_en`  in  4  per-digit enable; bit i controls digit i.
- `an`  out  4  anode selects, active-low, registered.
- `sseg`  out  7  segment drive, active-low, registered.
- `frame_start`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- **State held:** slot counter `cnt` (0..TICK_DIV-1), digit index `dig` (0..3), `active[4]` pattern registers, `shadow[4]` pattern registers, `pending` flag, latched enable `en_q`.
- **Slot states:**
  - BLANK while `cnt < BLANK_CYC`.
  - DRIVE otherwise.
  - With `BLANK_CYC = 0`, BLANK never occurs.
- **Output rule** (registered; computed from the current `cnt`/`dig`):
  - BLANK, or `en_q[dig] = 0` → `an = 4'b1111`, `sseg = 7'h7F`.
  - DRIVE with `en_q[dig] = 1` → `an = ~(4'b0001 << dig)`, `sseg = active[dig]`.
- **Slot end** (`cnt == TICK_DIV-1`):
  - `cnt` ← 0.
  - `dig` ← (`dig`+1) mod 4.
  - `en_q` ← `dig_en`, so enable changes take effect only at slot boundaries.
- **Frame wrap** (slot end with `dig == 3`):
  - `frame_start` ← 1 for exactly one cycle.
  - If `pending`, then `active` ← `shadow` and `pending` ← 0 on the same edge.
- **Load handshake:**
  - `load_ready = ~pending` (combinational).
  - Transfer happens when `load_valid & load_ready`: `shadow` ← `load_data` and `pending` ← 1.
  - At most one set is buffered. Further offers stall until the next frame wrap.
  - In a wrap cycle with `pending = 1`, `load_ready` is 0, so commit and accept never coincide.
  - `load_valid` with `load_ready = 0` has no effect.
- **Committed data** first appears on digit 0 of the frame that begins at the commit edge. A frame never mixes old and new patterns.
- **Reset** (async assert, any time, including mid-slot or with a load pending):
  - `cnt = 0`, `dig = 0`, `pending = 0`, `en_q = 4'b1111`.
  - `active` and `shadow` all 7'h7F.
  - `an = 4'b1111`, `sseg = 7'h7F`, `frame_start = 0`, `load_ready = 1`.
  - A pending set is discarded.

## Timing
- `an`/`sseg` lag the counter by one cycle.
- After reset release:
  - Outputs stay blank for `BLANK_CYC+1` cycles.
  - Digit 0 is then driven for `TICK_DIV-BLANK_CYC` cycles.
- Frame period is exactly `4*TICK_DIV` cycles.
- `frame_start` rises on the edge where `dig` becomes 0. No pulse is produced by reset itself.
- Handshake-to-display latency ranges from 1 frame wrap plus `BLANK_CYC+1` cycles (minimum) up to `4*TICK_DIV + BLANK_CYC + 1` cycles (maximum).
- `an` never has more than one bit low, and never has two different digits low on consecutive cycles when `BLANK_CYC ≥ 1`.

## Structure
- **Package `sseg_pkg`:**
  - `SEG_BLANK = 7'h7F`, `AN_OFF = 4'hF`, `NDIG = 4`.
  - Slot-state enum {BLANK, DRIVE}.
  - Helper to slice `load_data` into digit i.
- **Sub-module `slot_timer`:**
  - Parameter: `TICK_DIV`.
  - Outputs: `cnt` and a `slot_end` strobe.
  - The top level holds `dig`, the buffers, the handshake and the output registers.

## Test plan
Benches run with `TICK_DIV=8`, `BLANK_CYC=2`.

1. **Reset scan:** release reset, all `dig_en=1`, no load → `an` cycles 1111×3 then 1110×6, 1111×2 then 1101×6, …; `sseg` stays 7F throughout; `frame_start` pulses every 32 cycles.
2. **Load/commit:** load `{7'h40,7'h79,7'h24,7'h30}` mid-frame →
   - `load_ready` drops the cycle after the transfer.
   - At the next wrap, `frame_start` pulses and `load_ready` returns to 1.
   - Digit 0 shows `7'h30` and digit 3 shows `7'h40` during the following frame.
3. **Back-pressure:** hold `load_valid` with two different sets → the second set is accepted only in the cycle after the wrap, and the displayed frame never mixes the two sets.
4. **Digit enable:** `dig_en = 4'b0101` changed mid-slot of digit 1 → the current slot is unchanged; digits 1 and 3 then stay `an=1111`, `sseg=7F`.
5. **Reset mid-operation:** assert `reset` with `pending=1` in a DRIVE slot of digit 2 → `an=1111`, `sseg=7F`, `load_ready=1` immediately (asynchronously); after release, the scan restarts at digit 0 and the old shadow data never appears.
6. **No dead time:** with `BLANK_CYC=0`, `an` is never 1111 while all digits are enabled, and each digit is held for 8 cycles.
